forest_vote_scheduler: RTL and testbench
========================================

// Module: forest_vote_scheduler
// PURPOSE
//  Sequencer for the combinational classN_treeM decision-tree bank. Registers one
//  51-bit feature vector, drives it onto the shared tree-bank feature bus, waits for
//  the bank to settle, captures all tree votes, then tallies them one class per
//  cycle and returns the majority class over a valid/ready result channel.
// PARAMETERS
//  N_FEAT       51  feature vector width (tree-bank input i[N_FEAT-1:0])
//  NUM_CLASSES  4   classes in the forest, >=2
//  NUM_TREES    8   trees per class, >=1
//  SETTLE       1   cycles between feature drive and vote capture, >=1
//  (derived) CLS_W=$clog2(NUM_CLASSES), CNT_W=$clog2(NUM_TREES+1)
// PORTS
//  clk          in   1                      clock
//  rst          in   1                      synchronous reset, active-high
//  in_valid     in   1                      feature vector offered
//  in_ready     out  1                      scheduler can accept (IDLE only)
//  in_feat      in   N_FEAT                 feature vector
//  tree_feat    out  N_FEAT                 registered feature bus to tree bank
//  tree_votes   in   NUM_CLASSES*NUM_TREES  vote bit per tree; class c = bits [c*NUM_TREES +: NUM_TREES]
//  out_valid    out  1                      result available (held until out_ready)
//  out_ready    in   1                      consumer accepts result
//  out_class    out  CLS_W                  winning class index
//  out_votes    out  CNT_W                  vote count of winning class
//  out_none     out  1                      all classes scored zero
//  busy         out  1                      state != IDLE
// BEHAVIOUR
//  - Reset: state=IDLE; in_ready=1 (after reset deasserts); out_valid=0; out_class=0;
//    out_votes=0; out_none=0; tree_feat=0; busy=0; internal counters/best regs =0.
//  - Reset at any time aborts the in-flight vector; no result is emitted for it.
//  - FSM IDLE->EVAL->COUNT->DONE->IDLE:
//    IDLE : in_ready=1. On in_valid&in_ready at edge k: tree_feat<=in_feat, go EVAL.
//    EVAL : settle counter runs SETTLE cycles; at edge k+SETTLE votes_q<=tree_votes,
//           cls_idx<=0, best_cnt<=0, best_cls<=0, go COUNT.
//    COUNT: each cycle cnt=popcount(votes_q slice cls_idx); if cnt>best_cnt update
//           best (strict >: ties keep lower index). cls_idx==NUM_CLASSES-1 -> DONE.
//    DONE : out_valid=1, outputs stable; on out_ready go IDLE (out_valid=0 next cycle).
//  - Latency: out_valid high after edge k+SETTLE+NUM_CLASSES (defaults: 5 cycles after
//    accept). Throughput 1 vector per SETTLE+NUM_CLASSES+2 cycles with out_ready=1.
//  - tree_feat holds value from accept until next accept (stable through COUNT/DONE).
//  - tree_votes only sampled at end of EVAL; changes at other times ignored.
//  - in_valid while not IDLE: in_ready=0, vector not consumed, no state change.
//  - out_none=1 iff best_cnt==0 at DONE; then out_class=0, out_votes=0.
//  - out_votes width CNT_W holds NUM_TREES exactly; no saturation needed.
//  - out_class/out_votes/out_none update only on DONE entry; held through IDLE.
// STRUCTURE
//  - forest_pkg: N_FEAT default, state enum (IDLE,EVAL,COUNT,DONE), clog2-based
//    width helper functions.
//  - Sub-module forest_popcount #(W=NUM_TREES): combinational popcount -> CNT_W bits.
//  - Top holds FSM, settle counter, class index, votes_q, best regs, output regs.
// TESTING
//  1 Reset mid-COUNT (rst=1 one cycle) -> next cycle state IDLE, out_valid=0,
//    in_ready=1, no result ever emitted for aborted vector.
//  2 Defaults, votes class0=8'h01, class2=8'h3F, others 0; accept at edge k ->
//    out_valid at k+5, out_class=2, out_votes=6, out_none=0.
//  3 Tie: class1=8'h0F, class3=8'hF0 -> out_class=1, out_votes=4.
//  4 All votes 0 -> out_class=0, out_votes=0, out_none=1.
//  5 out_ready=0 for 10 cycles in DONE -> out_valid and outputs stable, in_ready=0,
//    second in_valid not accepted; after out_ready, IDLE then accepts it.
//  6 tree_votes toggled during COUNT/DONE and SETTLE=3 -> result reflects only value
//    present at edge k+3; out_valid at k+7; tree_feat equals accepted in_feat.

Source files
------------

// File: rtl/forest_vote_scheduler_pkg.sv
// Shared types and width helpers for the forest vote scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package forest_vote_scheduler_pkg;

  localparam int N_FEAT_DEF = 51;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EVAL,
    ST_COUNT,
    ST_DONE
  } state_t;

  // Class index width; a single class still needs one bit to carry index 0.
  function automatic int cls_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Vote count width, able to hold every value from 0 to n.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/forest_vote_scheduler_if.sv
// Feature-in / result-out valid-ready channels of the vote scheduler.
// Latency: n/a (wiring only).
// Backpressure: in_ready gates features, out_ready releases a held result.
interface forest_vote_scheduler_if #(
  parameter int N_FEAT      = forest_vote_scheduler_pkg::N_FEAT_DEF,
  parameter int NUM_CLASSES = 4,
  parameter int NUM_TREES   = 8
);
  import forest_vote_scheduler_pkg::*;

  localparam int CLS_W = cls_w(NUM_CLASSES);
  localparam int CNT_W = cnt_w(NUM_TREES);

  logic              in_valid;
  logic              in_ready;
  logic [N_FEAT-1:0] in_feat;
  logic              out_valid;
  logic              out_ready;
  logic [CLS_W-1:0]  out_class;
  logic [CNT_W-1:0]  out_votes;
  logic              out_none;

  modport master (
    output in_valid, in_feat, out_ready,
    input  in_ready, out_valid, out_class, out_votes, out_none
  );

  modport slave (
    input  in_valid, in_feat, out_ready,
    output in_ready, out_valid, out_class, out_votes, out_none
  );

endinterface

// File: rtl/forest_vote_scheduler_popcount.sv
// Counts set bits of one class's vote slice.
// Latency: combinational.
// Backpressure: none.
module forest_vote_scheduler_popcount #(
  parameter int W  = 8,
  parameter int CW = 4
) (
  input  logic [W-1:0]  bits,
  output logic [CW-1:0] cnt
);

  // Ripple sum of individual vote bits.
  always_comb begin
    cnt = '0;
    for (int i = 0; i < W; i++) begin
      cnt = cnt + CW'(bits[i]);
    end
  end

endmodule

// File: rtl/forest_vote_scheduler.sv
// Drives one feature vector to the tree bank, captures votes, tallies the majority class.
// Latency: result valid SETTLE+NUM_CLASSES cycles after accept.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
module forest_vote_scheduler
  import forest_vote_scheduler_pkg::*;
#(
  parameter int N_FEAT      = N_FEAT_DEF,
  parameter int NUM_CLASSES = 4,
  parameter int NUM_TREES   = 8,
  parameter int SETTLE      = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  forest_vote_scheduler_if.slave           bus,
  output logic [N_FEAT-1:0]                tree_feat,
  input  logic [NUM_CLASSES*NUM_TREES-1:0] tree_votes,
  output logic                             busy
);

  localparam int CLS_W = cls_w(NUM_CLASSES);
  localparam int CNT_W = cnt_w(NUM_TREES);
  localparam int VW    = NUM_CLASSES * NUM_TREES;
  localparam int SW    = cnt_w(SETTLE);

  state_t           state, state_nxt;
  logic [SW-1:0]    settle_cnt;
  logic [CLS_W-1:0] cls_idx;
  logic [VW-1:0]    votes_q;
  logic [CNT_W-1:0] best_cnt, cnt, cand_cnt;
  logic [CLS_W-1:0] best_cls, cand_cls;
  logic [CLS_W-1:0] out_class_q;
  logic [CNT_W-1:0] out_votes_q;
  logic             out_none_q;
  logic             accept, settle_done, last_cls;

  assign accept      = bus.in_valid && (state == ST_IDLE);
  assign settle_done = (settle_cnt == SW'(SETTLE - 1));
  assign last_cls    = (cls_idx == CLS_W'(NUM_CLASSES - 1));

  forest_vote_scheduler_popcount #(.W(NUM_TREES), .CW(CNT_W)) u_popcount (
    .bits (votes_q[cls_idx*NUM_TREES +: NUM_TREES]),
    .cnt  (cnt)
  );

  // Strict greater-than so a tie keeps the lower class index.
  always_comb begin
    cand_cnt = best_cnt;
    cand_cls = best_cls;
    if (cnt > best_cnt) begin
      cand_cnt = cnt;
      cand_cls = cls_idx;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept)        state_nxt = ST_EVAL;
      ST_EVAL:  if (settle_done)   state_nxt = ST_COUNT;
      ST_COUNT: if (last_cls)      state_nxt = ST_DONE;
      ST_DONE:  if (bus.out_ready) state_nxt = ST_IDLE;
      default:                     state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: feature latch, settle timer, vote capture, tally and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      tree_feat   <= '0;
      settle_cnt  <= '0;
      cls_idx     <= '0;
      votes_q     <= '0;
      best_cnt    <= '0;
      best_cls    <= '0;
      out_class_q <= '0;
      out_votes_q <= '0;
      out_none_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            tree_feat  <= bus.in_feat;
            settle_cnt <= '0;
          end
        end
        ST_EVAL: begin
          if (settle_done) begin
            votes_q  <= tree_votes;
            cls_idx  <= '0;
            best_cnt <= '0;
            best_cls <= '0;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        ST_COUNT: begin
          best_cnt <= cand_cnt;
          best_cls <= cand_cls;
          if (last_cls) begin
            out_class_q <= cand_cls;
            out_votes_q <= cand_cnt;
            out_none_q  <= (cand_cnt == '0);
          end else begin
            cls_idx <= cls_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == ST_IDLE);
  assign bus.out_valid = (state == ST_DONE);
  assign bus.out_class = out_class_q;
  assign bus.out_votes = out_votes_q;
  assign bus.out_none  = out_none_q;
  assign busy          = (state != ST_IDLE);

endmodule

// File: tb/tb_forest_vote_scheduler.sv
// Directed and random checks of the forest vote scheduler against a counting model.
// Latency: n/a.
// Backpressure: exercises held results and refused inputs.
module tb_forest_vote_scheduler;

  localparam int NF = 51;
  localparam int NC = 4;
  localparam int NT = 8;
  localparam int VW = NC * NT;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  forest_vote_scheduler_if #(.N_FEAT(NF), .NUM_CLASSES(NC), .NUM_TREES(NT)) bus_a ();
  forest_vote_scheduler_if #(.N_FEAT(NF), .NUM_CLASSES(NC), .NUM_TREES(NT)) bus_b ();

  logic [NF-1:0] tree_feat_a, tree_feat_b;
  logic [VW-1:0] votes_a, votes_b;
  logic          busy_a, busy_b;

  forest_vote_scheduler #(.N_FEAT(NF), .NUM_CLASSES(NC), .NUM_TREES(NT), .SETTLE(1)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a),
    .tree_feat(tree_feat_a), .tree_votes(votes_a), .busy(busy_a)
  );

  forest_vote_scheduler #(.N_FEAT(NF), .NUM_CLASSES(NC), .NUM_TREES(NT), .SETTLE(3)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b),
    .tree_feat(tree_feat_b), .tree_votes(votes_b), .busy(busy_b)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Majority by plain counting: highest count wins, first class wins ties.
  function automatic void model(input logic [VW-1:0] v, output int cls, output int cnt);
    int k;
    cls = 0;
    cnt = 0;
    for (int c = 0; c < NC; c++) begin
      k = 0;
      for (int t = 0; t < NT; t++) k += int'(v[c*NT + t]);
      if (k > cnt) begin
        cnt = k;
        cls = c;
      end
    end
  endfunction

  function automatic logic [NF-1:0] rand_feat();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[NF-1:0];
  endfunction

  // One full transaction on the SETTLE=1 instance, releasing the result immediately.
  task automatic xact_a(input string tag, input logic [VW-1:0] votes);
    logic [NF-1:0] f;
    int n, ec, ev;
    f = rand_feat();
    model(votes, ec, ev);
    bus_a.in_valid = 1'b1;
    bus_a.in_feat  = f;
    votes_a        = votes;
    chk({tag, ".in_ready"}, 64'(bus_a.in_ready), 64'd1);
    @(negedge clk);
    bus_a.in_valid = 1'b0;
    chk({tag, ".tree_feat"}, 64'(tree_feat_a), 64'(f));
    n = 0;
    while (!bus_a.out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".latency"}, 64'(n), 64'd5);
    chk({tag, ".class"}, 64'(bus_a.out_class), 64'(ec));
    chk({tag, ".votes"}, 64'(bus_a.out_votes), 64'(ev));
    chk({tag, ".none"}, 64'(bus_a.out_none), 64'(ev == 0));
    bus_a.out_ready = 1'b1;
    @(negedge clk);
    bus_a.out_ready = 1'b0;
    chk({tag, ".drop_valid"}, 64'(bus_a.out_valid), 64'd0);
    chk({tag, ".held_class"}, 64'(bus_a.out_class), 64'(ec));
  endtask

  initial begin
    logic [NF-1:0] f1, f2;
    logic [VW-1:0] v1, v2;
    int n, ec, ev, ec2, ev2;
    logic seen, stable;

    rst = 1'b1;
    bus_a.in_valid = 1'b0; bus_a.in_feat = '0; bus_a.out_ready = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.in_feat = '0; bus_b.out_ready = 1'b0;
    votes_a = '0;
    votes_b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("rst.in_ready", 64'(bus_a.in_ready), 64'd1);
    chk("rst.out_valid", 64'(bus_a.out_valid), 64'd0);
    chk("rst.out_class", 64'(bus_a.out_class), 64'd0);
    chk("rst.out_votes", 64'(bus_a.out_votes), 64'd0);
    chk("rst.out_none", 64'(bus_a.out_none), 64'd0);
    chk("rst.tree_feat", 64'(tree_feat_a), 64'd0);
    chk("rst.busy", 64'(busy_a), 64'd0);

    // Abort a vector with reset while it is being tallied.
    bus_a.in_valid = 1'b1;
    bus_a.in_feat  = rand_feat();
    votes_a        = 32'hFFFF_FFFF;
    @(negedge clk);
    bus_a.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort.busy_before", 64'(busy_a), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort.busy", 64'(busy_a), 64'd0);
    chk("abort.out_valid", 64'(bus_a.out_valid), 64'd0);
    chk("abort.in_ready", 64'(bus_a.in_ready), 64'd1);
    chk("abort.tree_feat", 64'(tree_feat_a), 64'd0);
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (bus_a.out_valid) seen = 1'b1;
    end
    chk("abort.no_result", 64'(seen), 64'd0);

    xact_a("majority", 32'h003F_0001);
    xact_a("tie", 32'hF000_0F00);
    xact_a("all_zero", 32'h0000_0000);
    xact_a("all_ones", 32'hFFFF_FFFF);
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) xact_a("rand", VW'($urandom()));
      else            xact_a("rand_sparse", VW'($urandom() & $urandom() & $urandom()));
    end

    // Hold the result for ten cycles while a second vector waits.
    f1 = rand_feat();
    f2 = rand_feat();
    v1 = 32'h0301_0F07;
    v2 = VW'($urandom());
    model(v1, ec, ev);
    model(v2, ec2, ev2);
    bus_a.in_valid = 1'b1;
    bus_a.in_feat  = f1;
    votes_a        = v1;
    @(negedge clk);
    bus_a.in_valid = 1'b0;
    n = 0;
    while (!bus_a.out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("hold.latency", 64'(n), 64'd5);
    bus_a.in_valid = 1'b1;
    bus_a.in_feat  = f2;
    votes_a        = v2;
    stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!bus_a.out_valid || bus_a.in_ready || bus_a.out_class !== 2'(ec) ||
          bus_a.out_votes !== 4'(ev) || tree_feat_a !== f1)
        stable = 1'b0;
    end
    chk("hold.stable", 64'(stable), 64'd1);
    chk("hold.class", 64'(bus_a.out_class), 64'(ec));
    bus_a.out_ready = 1'b1;
    @(negedge clk);
    bus_a.out_ready = 1'b0;
    chk("hold.idle_ready", 64'(bus_a.in_ready), 64'd1);
    chk("hold.idle_valid", 64'(bus_a.out_valid), 64'd0);
    @(negedge clk);
    bus_a.in_valid = 1'b0;
    chk("hold.second_feat", 64'(tree_feat_a), 64'(f2));
    chk("hold.second_busy", 64'(busy_a), 64'd1);
    n = 0;
    while (!bus_a.out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("hold.second_latency", 64'(n), 64'd5);
    chk("hold.second_class", 64'(bus_a.out_class), 64'(ec2));
    chk("hold.second_votes", 64'(bus_a.out_votes), 64'(ev2));
    bus_a.out_ready = 1'b1;
    @(negedge clk);
    bus_a.out_ready = 1'b0;

    // SETTLE=3: only the votes present at the capture edge may count.
    for (int r = 0; r < 4; r++) begin
      f1 = rand_feat();
      v1 = (r == 0) ? 32'h0000_FF00 : VW'($urandom());
      model(v1, ec, ev);
      bus_b.in_valid = 1'b1;
      bus_b.in_feat  = f1;
      votes_b        = VW'($urandom());
      @(negedge clk);
      bus_b.in_valid = 1'b0;
      n = 0;
      while (!bus_b.out_valid && n < 40) begin
        if (n == 2) votes_b = v1;
        else        votes_b = VW'($urandom());
        @(negedge clk);
        n++;
      end
      chk("settle3.latency", 64'(n), 64'd7);
      chk("settle3.tree_feat", 64'(tree_feat_b), 64'(f1));
      chk("settle3.class", 64'(bus_b.out_class), 64'(ec));
      chk("settle3.votes", 64'(bus_b.out_votes), 64'(ev));
      chk("settle3.none", 64'(bus_b.out_none), 64'(ev == 0));
      bus_b.out_ready = 1'b1;
      @(negedge clk);
      bus_b.out_ready = 1'b0;
      chk("settle3.idle", 64'(busy_b), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
